// File: rtl/fpu_aux_arbiter.sv
// Shares one fpu_float_aux datapath among num_req_p requesters: round-robin grant
// into an issue register, response register with back-pressure, per-requester sticky flags.
package fpu_aux_arbiter_pkg;
   typedef enum logic [3:0] {
      eFSGNJ, eFSGNJN, eFSGNJX, eFMIN, eFMAX, eFEQ, eFLT, eFLE,
      eFCLASS, eFCVT_S_W, eFCVT_S_WU, eFCVT_W_S, eFCVT_WU_S, eFMV_X_W, eFMV_W_X, eFSQRT
   } fpu_float_op_e;
endpackage

module fpu_aux_arbiter
   import fpu_aux_arbiter_pkg::*;
#(
   parameter  int num_req_p    = 2,
   parameter  int data_width_p = 33,
   parameter  int tag_width_p  = 5,
   localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,
   input  logic [num_req_p-1:0]                     req_v_i,
   input  fpu_float_op_e [num_req_p-1:0]            req_op_i,
   input  logic [num_req_p-1:0][data_width_p-1:0]   req_rs1_i,
   input  logic [num_req_p-1:0][data_width_p-1:0]   req_rs2_i,
   input  logic [num_req_p-1:0][2:0]                req_rm_i,
   input  logic [num_req_p-1:0][tag_width_p-1:0]    req_tag_i,
   output logic [num_req_p-1:0]                     req_yumi_o,
   output fpu_float_op_e                            aux_op_o,
   output logic [data_width_p-1:0]                  aux_rs1_o,
   output logic [data_width_p-1:0]                  aux_rs2_o,
   output logic [2:0]                               aux_rm_o,
   output logic                                     aux_v_o,
   input  logic                                     aux_v_i,
   input  logic [data_width_p-1:0]                  aux_result_i,
   input  logic [4:0]                               aux_fflags_i,
   output logic                                     resp_v_o,
   input  logic                                     resp_ready_i,
   output logic [id_width_lp-1:0]                   resp_id_o,
   output logic [tag_width_p-1:0]                   resp_tag_o,
   output logic [data_width_p-1:0]                  resp_result_o,
   output logic                                     resp_illegal_o,
   input  logic [num_req_p-1:0]                     fflags_clr_i,
   output logic [num_req_p-1:0][4:0]                fflags_acc_o
);

   logic                              r_live;
   logic [id_width_lp-1:0]            r_prio;

   logic                              r_ir_v;
   fpu_float_op_e                     r_ir_op;
   logic [data_width_p-1:0]           r_ir_rs1;
   logic [data_width_p-1:0]           r_ir_rs2;
   logic [2:0]                        r_ir_rm;
   logic [id_width_lp-1:0]            r_ir_id;
   logic [tag_width_p-1:0]            r_ir_tag;

   logic                              r_rr_v;
   logic [data_width_p-1:0]           r_rr_result;
   logic [4:0]                        r_rr_fflags;
   logic                              r_rr_illegal;
   logic [id_width_lp-1:0]            r_rr_id;
   logic [tag_width_p-1:0]            r_rr_tag;

   logic [num_req_p-1:0][4:0]         r_fflags_acc;

   logic                              w_resp_hs;
   logic                              w_ir_adv;
   logic                              w_ir_free;
   logic                              w_gnt_v;
   logic [id_width_lp-1:0]            w_gnt_id;
   logic [num_req_p-1:0]              w_yumi;
   logic [id_width_lp:0]              w_scan_sum;
   logic [id_width_lp-1:0]            w_scan_idx;

   assign w_resp_hs = r_rr_v & resp_ready_i;
   assign w_ir_adv  = r_ir_v & (~r_rr_v | resp_ready_i);
   assign w_ir_free = ~r_ir_v | w_ir_adv;

   // Round-robin scan starting at r_prio; r_live blocks the edge that releases reset.
   always_comb begin
      w_yumi     = '0;
      w_gnt_v    = 1'b0;
      w_gnt_id   = '0;
      w_scan_sum = '0;
      w_scan_idx = '0;
      for (int k = 0; k < num_req_p; k++) begin
         w_scan_sum = {1'b0, r_prio} + (id_width_lp+1)'(k);
         if (w_scan_sum >= (id_width_lp+1)'(num_req_p))
            w_scan_sum = w_scan_sum - (id_width_lp+1)'(num_req_p);
         w_scan_idx = w_scan_sum[id_width_lp-1:0];
         if (!w_gnt_v && req_v_i[w_scan_idx] && w_ir_free && r_live) begin
            w_gnt_v  = 1'b1;
            w_gnt_id = w_scan_idx;
         end
      end
      if (w_gnt_v)
         w_yumi[w_gnt_id] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_live       <= 1'b0;
         r_prio       <= '0;
         r_ir_v       <= 1'b0;
         r_rr_v       <= 1'b0;
         r_fflags_acc <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_gnt_v)
            r_prio <= (w_gnt_id == id_width_lp'(num_req_p - 1)) ? '0 : w_gnt_id + 1'b1;
         if (w_gnt_v)
            r_ir_v <= 1'b1;
         else if (w_ir_adv)
            r_ir_v <= 1'b0;
         if (w_ir_adv)
            r_rr_v <= 1'b1;
         else if (w_resp_hs)
            r_rr_v <= 1'b0;
         // A clear landing with an update keeps only the new flags.
         for (int k = 0; k < num_req_p; k++) begin
            if (w_resp_hs && !r_rr_illegal && (r_rr_id == id_width_lp'(k)))
               r_fflags_acc[k] <= (fflags_clr_i[k] ? 5'b0 : r_fflags_acc[k]) | r_rr_fflags;
            else if (fflags_clr_i[k])
               r_fflags_acc[k] <= '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_gnt_v) begin
         r_ir_op  <= req_op_i[w_gnt_id];
         r_ir_rs1 <= req_rs1_i[w_gnt_id];
         r_ir_rs2 <= req_rs2_i[w_gnt_id];
         r_ir_rm  <= req_rm_i[w_gnt_id];
         r_ir_id  <= w_gnt_id;
         r_ir_tag <= req_tag_i[w_gnt_id];
      end
      if (w_ir_adv) begin
         r_rr_result  <= aux_result_i;
         r_rr_fflags  <= aux_fflags_i;
         r_rr_illegal <= ~aux_v_i;
         r_rr_id      <= r_ir_id;
         r_rr_tag     <= r_ir_tag;
      end
   end

   assign req_yumi_o     = w_yumi;
   assign aux_op_o       = r_ir_op;
   assign aux_rs1_o      = r_ir_rs1;
   assign aux_rs2_o      = r_ir_rs2;
   assign aux_rm_o       = r_ir_rm;
   assign aux_v_o        = r_ir_v;
   assign resp_v_o       = r_rr_v;
   assign resp_id_o      = r_rr_id;
   assign resp_tag_o     = r_rr_tag;
   assign resp_result_o  = r_rr_result;
   assign resp_illegal_o = r_rr_illegal;
   assign fflags_acc_o   = r_fflags_acc;

endmodule
